// File: rtl/rr_arbiter.sv
// Eight-way round-robin arbiter: rotating-pointer first-set search, grant held
// until request drops or a hold timeout preempts, one idle cycle between grants.
module rr_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_valid,
   output logic       preempt
);

   localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [2:0]      ptr, ptr_nxt;
   logic [CW-1:0]   hold_cnt, hold_nxt;
   logic [7:0]      gnt_nxt;
   logic [2:0]      id_nxt;
   logic            valid_nxt;
   logic            preempt_nxt;

   logic            found;
   logic [2:0]      win;
   logic [2:0]      idx;

   // First set request bit scanning upward from ptr, wrapping at 8.
   always_comb begin
      found = 1'b0;
      win   = 3'd0;
      idx   = 3'd0;
      for (int i = 0; i < 8; i++) begin
         idx = ptr + 3'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      gnt_nxt     = gnt;
      id_nxt      = gnt_id;
      ptr_nxt     = ptr;
      hold_nxt    = hold_cnt;
      preempt_nxt = 1'b0;
      case (state)
         IDLE, GAP: begin
            if (found) begin
               state_nxt = GRANT;
               gnt_nxt   = 8'd1 << win;
               id_nxt    = win;
               hold_nxt  = '0;
            end else begin
               state_nxt = IDLE;
               gnt_nxt   = 8'h00;
               id_nxt    = 3'd0;
            end
         end
         GRANT: begin
            // Release is checked first so a voluntary drop never reports preempt.
            if (!req[gnt_id]) begin
               state_nxt = GAP;
               gnt_nxt   = 8'h00;
               id_nxt    = 3'd0;
               ptr_nxt   = gnt_id + 3'd1;
            end else if ((hold_cnt == HOLD_LAST) && ((req & ~gnt) != 8'h00)) begin
               state_nxt   = GAP;
               gnt_nxt     = 8'h00;
               id_nxt      = 3'd0;
               ptr_nxt     = gnt_id + 3'd1;
               preempt_nxt = 1'b1;
            end else if (hold_cnt != HOLD_LAST) begin
               hold_nxt = hold_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = 8'h00;
            id_nxt    = 3'd0;
         end
      endcase
      valid_nxt = |gnt_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= 3'd0;
         hold_cnt  <= '0;
         gnt       <= 8'h00;
         gnt_id    <= 3'd0;
         gnt_valid <= 1'b0;
         preempt   <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         hold_cnt  <= hold_nxt;
         gnt       <= gnt_nxt;
         gnt_id    <= id_nxt;
         gnt_valid <= valid_nxt;
         preempt   <= preempt_nxt;
      end
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: reset, rotation, wrap, timeout, lone holder,
// release-vs-timeout priority and asynchronous reset mid-grant.
module tb_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       preempt;

   int checks;
   int errors;

   logic [12:0] obs;
   assign obs = {gnt, gnt_id, gnt_valid, preempt};

   rr_arbiter #(.MAX_HOLD(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {gnt, gnt_id, gnt_valid, preempt} for a grant to id (v=1) or no grant (v=0).
   function automatic logic [12:0] exp_st(input logic [2:0] id, input logic v, input logic p);
      logic [7:0] g;
      g = v ? (8'd1 << id) : 8'h00;
      return {g, (v ? id : 3'd0), v, p};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 8'h00;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 8'hFF;
      tick();
      tick();
      checks++;
      if (obs !== exp_st(3'd0, 1'b0, 1'b0)) begin
         errors++;
         $display("FAIL reset_hold got=%h exp=%h", obs, exp_st(3'd0, 1'b0, 1'b0));
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (obs !== exp_st(3'd0, 1'b1, 1'b0)) begin
         errors++;
         $display("FAIL reset_first_grant got=%h exp=%h", obs, exp_st(3'd0, 1'b1, 1'b0));
      end
      req = 8'h00;
      tick();
      tick();
   endtask

   task automatic test_rotation();
      logic [2:0] order [4];
      order[0] = 3'd0; order[1] = 3'd2; order[2] = 3'd5; order[3] = 3'd0;
      do_reset();
      req = 8'b0010_0101;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (obs !== exp_st(order[i], 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL rotation_grant[%0d] got=%h exp=%h", i, obs, exp_st(order[i], 1'b1, 1'b0));
         end
         tick();
         checks++;
         if (obs !== exp_st(order[i], 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL rotation_hold[%0d] got=%h exp=%h", i, obs, exp_st(order[i], 1'b1, 1'b0));
         end
         req[order[i]] = 1'b0;
         tick();
         checks++;
         if (obs !== exp_st(3'd0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL rotation_gap[%0d] got=%h exp=%h", i, obs, exp_st(3'd0, 1'b0, 1'b0));
         end
         req[order[i]] = 1'b1;
      end
      req = 8'h00;
      tick();
      tick();
   endtask

   task automatic test_wrap();
      do_reset();
      req = 8'h20;
      tick();
      checks++;
      if (obs !== exp_st(3'd5, 1'b1, 1'b0)) begin
         errors++;
         $display("FAIL wrap_setup got=%h exp=%h", obs, exp_st(3'd5, 1'b1, 1'b0));
      end
      req = 8'h00;
      tick();
      req = 8'b1000_0010;
      tick();
      checks++;
      if (obs !== exp_st(3'd7, 1'b1, 1'b0)) begin
         errors++;
         $display("FAIL wrap_grant7 got=%h exp=%h", obs, exp_st(3'd7, 1'b1, 1'b0));
      end
      req = 8'b0000_0010;
      tick();
      checks++;
      if (obs !== exp_st(3'd0, 1'b0, 1'b0)) begin
         errors++;
         $display("FAIL wrap_gap got=%h exp=%h", obs, exp_st(3'd0, 1'b0, 1'b0));
      end
      tick();
      checks++;
      if (obs !== exp_st(3'd1, 1'b1, 1'b0)) begin
         errors++;
         $display("FAIL wrap_grant1 got=%h exp=%h", obs, exp_st(3'd1, 1'b1, 1'b0));
      end
      req = 8'h00;
      tick();
      tick();
   endtask

   task automatic test_timeout();
      logic [2:0] holder [3];
      holder[0] = 3'd0; holder[1] = 3'd3; holder[2] = 3'd0;
      do_reset();
      req = 8'b0000_1001;
      for (int h = 0; h < 2; h++) begin
         for (int c = 0; c < 16; c++) begin
            tick();
            checks++;
            if (obs !== exp_st(holder[h], 1'b1, 1'b0)) begin
               errors++;
               $display("FAIL timeout_hold[%0d][%0d] got=%h exp=%h", h, c, obs, exp_st(holder[h], 1'b1, 1'b0));
            end
         end
         tick();
         checks++;
         if (obs !== exp_st(3'd0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL timeout_gap[%0d] got=%h exp=%h", h, obs, exp_st(3'd0, 1'b0, 1'b1));
         end
      end
      tick();
      checks++;
      if (obs !== exp_st(holder[2], 1'b1, 1'b0)) begin
         errors++;
         $display("FAIL timeout_back got=%h exp=%h", obs, exp_st(holder[2], 1'b1, 1'b0));
      end
      req = 8'h00;
      tick();
      tick();
   endtask

   task automatic test_release_priority();
      do_reset();
      req = 8'b0000_1001;
      for (int c = 0; c < 16; c++) tick();
      checks++;
      if (obs !== exp_st(3'd0, 1'b1, 1'b0)) begin
         errors++;
         $display("FAIL relprio_last_hold got=%h exp=%h", obs, exp_st(3'd0, 1'b1, 1'b0));
      end
      req = 8'b0000_1000;
      tick();
      checks++;
      if (obs !== exp_st(3'd0, 1'b0, 1'b0)) begin
         errors++;
         $display("FAIL relprio_gap got=%h exp=%h", obs, exp_st(3'd0, 1'b0, 1'b0));
      end
      tick();
      checks++;
      if (obs !== exp_st(3'd3, 1'b1, 1'b0)) begin
         errors++;
         $display("FAIL relprio_next got=%h exp=%h", obs, exp_st(3'd3, 1'b1, 1'b0));
      end
      req = 8'h00;
      tick();
      tick();
   endtask

   task automatic test_lone_holder();
      do_reset();
      req = 8'h10;
      for (int c = 0; c < 40; c++) begin
         tick();
         checks++;
         if (obs !== exp_st(3'd4, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL lone_hold[%0d] got=%h exp=%h", c, obs, exp_st(3'd4, 1'b1, 1'b0));
         end
      end
      req = 8'h00;
      tick();
      tick();
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 8'h01;
      tick();
      req = 8'h00;
      tick();
      req = 8'h08;
      tick();
      checks++;
      if (obs !== exp_st(3'd3, 1'b1, 1'b0)) begin
         errors++;
         $display("FAIL async_setup got=%h exp=%h", obs, exp_st(3'd3, 1'b1, 1'b0));
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== exp_st(3'd0, 1'b0, 1'b0)) begin
         errors++;
         $display("FAIL async_drop got=%h exp=%h", obs, exp_st(3'd0, 1'b0, 1'b0));
      end
      rst_n = 1'b1;
      req   = 8'b0000_1001;
      tick();
      checks++;
      if (obs !== exp_st(3'd0, 1'b1, 1'b0)) begin
         errors++;
         $display("FAIL async_ptr_reset got=%h exp=%h", obs, exp_st(3'd0, 1'b1, 1'b0));
      end
      req = 8'h00;
      tick();
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      req    = 8'h00;
      test_reset();
      test_rotation();
      test_wrap();
      test_timeout();
      test_release_priority();
      test_lone_holder();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
